// File: rtl/cpu_pkg.sv
// Shared constants for the single-cycle MIPS-subset core: opcodes, R-type funct codes,
// the 4-bit ALU operation encoding and instruction field bit positions.
// Ports: none (package).
package cpu_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;

  // ALU operation encoding
  typedef enum logic [3:0] {
    AluAnd = 4'd0,
    AluOr  = 4'd1,
    AluAdd = 4'd2,
    AluSub = 4'd6,
    AluSlt = 4'd7,
    AluNor = 4'd12
  } alu_op_e;

  // Instruction field bit positions
  localparam int unsigned OpMsb     = 31;
  localparam int unsigned OpLsb     = 26;
  localparam int unsigned RsMsb     = 25;
  localparam int unsigned RsLsb     = 21;
  localparam int unsigned RtMsb     = 20;
  localparam int unsigned RtLsb     = 16;
  localparam int unsigned RdMsb     = 15;
  localparam int unsigned RdLsb     = 11;
  localparam int unsigned ShamtMsb  = 10;
  localparam int unsigned ShamtLsb  = 6;
  localparam int unsigned FunctMsb  = 5;
  localparam int unsigned FunctLsb  = 0;
  localparam int unsigned ImmMsb    = 15;
  localparam int unsigned ImmLsb    = 0;
  localparam int unsigned TargetMsb = 25;
  localparam int unsigned TargetLsb = 0;

  function automatic logic [31:0] sign_ext16(logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// 32-bit ALU for the MIPS-subset core.
// Ports: a_i/b_i operands, op_i operation (alu_op_e), result_o, zero_o (result == 0).
module alu
  import cpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      AluAnd:  result_o = a_i & b_i;
      AluOr:   result_o = a_i | b_i;
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = a_i - b_i;
      AluSlt:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      AluNor:  result_o = ~(a_i | b_i);
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == 32'h0);

endmodule

// File: rtl/cpu_dmem.sv
// Data memory: combinational read, write on the rising edge. Contents are not reset.
// Depth must be a power of two no larger than 256 so the word index wraps naturally.
// Ports: clk_i, we_i write enable, addr_i word index, wdata_i, rdata_o.
module DataMemory #(
  parameter int unsigned Depth = 256
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [31:0] data [0:Depth-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      data[addr_i[Aw-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = data[addr_i[Aw-1:0]];

endmodule

// File: rtl/cpu_imem.sv
// Instruction memory with combinational read. The write port exists only so the array has a
// driver in hardware; the core ties it off and programs are preloaded through the hierarchy.
// Depth must be a power of two no larger than 256 so the word index wraps naturally.
// Ports: clk_i, we_i/waddr_i/wdata_i (tied off), raddr_i word index, rdata_o instruction.
module InstructionMemory #(
  parameter int unsigned Depth = 256
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  raddr_i,
  output logic [31:0] rdata_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [31:0] data [0:Depth-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      data[waddr_i[Aw-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = data[raddr_i[Aw-1:0]];

endmodule

// File: rtl/cpu_registers.sv
// 32 x 32-bit register file, two combinational read ports, one write port on the rising edge.
// Register 0 reads as zero and ignores writes. Contents are not reset.
// Ports: clk_i, we_i/waddr_i/wdata_i write port, raddr_a_i/rdata_a_o and raddr_b_i/rdata_b_o.
module Registers (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o
);

  logic [31:0] data [0:31];

  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i != 5'd0)) begin
      data[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'h0 : data[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'h0 : data[raddr_b_i];

endmodule

// File: rtl/cpu.sv
// Single-cycle MIPS-subset core: add/sub/and/or/nor/slt, addi, lw/sw, beq/bne, one
// instruction committed per rising edge. Holds its own instruction memory, register file and
// data memory. Define CPU_JUMP_EN to enable the j instruction (opcode 0x02); otherwise it
// behaves as an unknown opcode (NOP).
// Ports: clock (rising-edge), reset (asynchronous, active-low; PC held at 0, writes blocked).
module cpu
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256
) (
  input  logic clock,
  input  logic reset
);

  logic [31:0] pc_q, pc_d, pc_plus4, instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, dst;
  logic [31:0] imm_ext, branch_target;
  logic [31:0] rs_data, rt_data, alu_b, alu_result, dmem_rdata, wb_data;
  logic        alu_zero;

  // Control
  alu_op_e alu_op;
  logic    reg_we, mem_we, alu_src_imm, reg_dst_rd, mem_to_reg, is_beq, is_bne;
`ifdef CPU_JUMP_EN
  logic    is_j;
  logic [25:0] target;
  assign target = instr[TargetMsb:TargetLsb];
`endif

  logic unused_shamt;
  assign unused_shamt = ^instr[ShamtMsb:ShamtLsb];

  assign opcode  = instr[OpMsb:OpLsb];
  assign rs      = instr[RsMsb:RsLsb];
  assign rt      = instr[RtMsb:RtLsb];
  assign rd      = instr[RdMsb:RdLsb];
  assign funct   = instr[FunctMsb:FunctLsb];
  assign imm_ext = sign_ext16(instr[ImmMsb:ImmLsb]);

  InstructionMemory #(
    .Depth(IMEM_DEPTH)
  ) InstructionMemory_0 (
    .clk_i  (clock),
    .we_i   (1'b0),
    .waddr_i(8'h00),
    .wdata_i(32'h0),
    .raddr_i(pc_q[9:2]),
    .rdata_o(instr)
  );

  always_comb begin
    reg_we      = 1'b0;
    mem_we      = 1'b0;
    alu_op      = AluAdd;
    alu_src_imm = 1'b0;
    reg_dst_rd  = 1'b0;
    mem_to_reg  = 1'b0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
`ifdef CPU_JUMP_EN
    is_j        = 1'b0;
`endif
    case (opcode)
      OpRtype: begin
        reg_dst_rd = 1'b1;
        reg_we     = 1'b1;
        case (funct)
          FnAdd:   alu_op = AluAdd;
          FnSub:   alu_op = AluSub;
          FnAnd:   alu_op = AluAnd;
          FnOr:    alu_op = AluOr;
          FnNor:   alu_op = AluNor;
          FnSlt:   alu_op = AluSlt;
          default: reg_we = 1'b0;
        endcase
      end
      OpAddi: begin
        alu_src_imm = 1'b1;
        reg_we      = 1'b1;
      end
      OpLw: begin
        alu_src_imm = 1'b1;
        mem_to_reg  = 1'b1;
        reg_we      = 1'b1;
      end
      OpSw: begin
        alu_src_imm = 1'b1;
        mem_we      = 1'b1;
      end
      OpBeq: begin
        alu_op = AluSub;
        is_beq = 1'b1;
      end
      OpBne: begin
        alu_op = AluSub;
        is_bne = 1'b1;
      end
`ifdef CPU_JUMP_EN
      OpJ: is_j = 1'b1;
`endif
      default: ;
    endcase
  end

  assign dst = reg_dst_rd ? rd : rt;

  Registers Registers_0 (
    .clk_i    (clock),
    .we_i     (reg_we & reset),
    .waddr_i  (dst),
    .wdata_i  (wb_data),
    .raddr_a_i(rs),
    .rdata_a_o(rs_data),
    .raddr_b_i(rt),
    .rdata_b_o(rt_data)
  );

  assign alu_b = alu_src_imm ? imm_ext : rt_data;

  alu alu_0 (
    .a_i     (rs_data),
    .b_i     (alu_b),
    .op_i    (alu_op),
    .result_o(alu_result),
    .zero_o  (alu_zero)
  );

  DataMemory #(
    .Depth(DMEM_DEPTH)
  ) DataMemory_0 (
    .clk_i  (clock),
    .we_i   (mem_we & reset),
    .addr_i (alu_result[9:2]),
    .wdata_i(rt_data),
    .rdata_o(dmem_rdata)
  );

  assign wb_data = mem_to_reg ? dmem_rdata : alu_result;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};

  always_comb begin
    pc_d = pc_plus4;
    if ((is_beq && alu_zero) || (is_bne && !alu_zero)) begin
      pc_d = branch_target;
    end
`ifdef CPU_JUMP_EN
    if (is_j) begin
      pc_d = {pc_plus4[31:28], target, 2'b00};
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for the single-cycle cpu: programs are preloaded through the fixed
// hierarchy, expected values are queued when a program is set up and popped as state is sampled.
module tb_cpu;
  import cpu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  cpu #(
    .IMEM_DEPTH(256),
    .DMEM_DEPTH(256)
  ) dut (
    .clock(clock),
    .reset(reset)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic void push_exp(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endfunction

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Hold reset, clear program memory to NOPs, preset r[i] = i.
  task automatic prog_begin();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) dut.InstructionMemory_0.data[i] = 32'h0;
    for (int i = 0; i < 32; i++) dut.Registers_0.data[i] = 32'(i);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    // Reset state; writes blocked and PC held while reset low
    prog_begin();
    dut.InstructionMemory_0.data[0] = 32'h012A4020;
    push_exp("rst_pc", 32'd0);
    push_exp("rst_r8_held", 32'd8);
    repeat (3) @(posedge clock);
    #1;
    pop_check(dut.pc_q);
    pop_check(dut.Registers_0.data[8]);

    // add $8,$9,$10
    push_exp("add_pc", 32'd4);
    push_exp("add_r8", 32'd19);
    release_reset();
    step();
    pop_check(dut.pc_q);
    pop_check(dut.Registers_0.data[8]);

    // sub $8,$9,$10
    prog_begin();
    dut.InstructionMemory_0.data[0] = 32'h012A4022;
    push_exp("sub_r8", 32'hFFFF_FFFF);
    release_reset();
    step();
    pop_check(dut.Registers_0.data[8]);

    // sw / lw, then sw with offset: $10 + 8 = 18 -> word 4
    prog_begin();
    dut.InstructionMemory_0.data[0] = 32'hAC090000;
    dut.InstructionMemory_0.data[1] = 32'h8C080000;
    dut.InstructionMemory_0.data[2] = enc_i(OpSw, 10, 9, 16'd8);
    dut.DataMemory_0.data[0] = 32'hDEAD_BEEF;
    dut.DataMemory_0.data[4] = 32'h0;
    push_exp("sw_mem0", 32'd9);
    push_exp("lw_r8", 32'd9);
    push_exp("sw_off_mem4", 32'd9);
    push_exp("ldst_pc", 32'd12);
    release_reset();
    step();
    pop_check(dut.DataMemory_0.data[0]);
    step();
    pop_check(dut.Registers_0.data[8]);
    step();
    pop_check(dut.DataMemory_0.data[4]);
    pop_check(dut.pc_q);

    // beq taken
    prog_begin();
    dut.InstructionMemory_0.data[0] = 32'h10000002;
    push_exp("beq_pc", 32'd12);
    release_reset();
    step();
    pop_check(dut.pc_q);

    // bne not taken, NOP, bne taken backwards (8+4-8 = 4)
    prog_begin();
    dut.InstructionMemory_0.data[0] = 32'h14000002;
    dut.InstructionMemory_0.data[2] = enc_i(OpBne, 9, 10, 16'hFFFE);
    push_exp("bne_nt_pc", 32'd4);
    push_exp("nop_pc", 32'd8);
    push_exp("bne_back_pc", 32'd4);
    release_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      pop_check(dut.pc_q);
    end

    // Write to $0 discarded
    prog_begin();
    dut.InstructionMemory_0.data[0] = 32'h012A0020;
    push_exp("r0_zero", 32'd0);
    push_exp("r0_r8", 32'd8);
    push_exp("r0_r9", 32'd9);
    push_exp("r0_r31", 32'd31);
    push_exp("r0_pc", 32'd4);
    release_reset();
    step();
    pop_check(dut.Registers_0.data[0]);
    pop_check(dut.Registers_0.data[8]);
    pop_check(dut.Registers_0.data[9]);
    pop_check(dut.Registers_0.data[31]);
    pop_check(dut.pc_q);

    // Logic ops, signed slt, addi negative, add wrap
    prog_begin();
    dut.InstructionMemory_0.data[0] = enc_r(9, 10, 11, FnAnd);
    dut.InstructionMemory_0.data[1] = enc_r(9, 10, 12, FnOr);
    dut.InstructionMemory_0.data[2] = enc_r(9, 10, 13, FnNor);
    dut.InstructionMemory_0.data[3] = enc_r(9, 10, 14, FnSlt);
    dut.InstructionMemory_0.data[4] = enc_i(OpAddi, 0, 15, 16'hFFFF);
    dut.InstructionMemory_0.data[5] = enc_r(15, 1, 16, FnSlt);
    dut.InstructionMemory_0.data[6] = enc_r(1, 15, 22, FnSlt);
    dut.InstructionMemory_0.data[7] = enc_r(15, 1, 17, FnAdd);
    dut.InstructionMemory_0.data[8] = enc_i(OpAddi, 9, 23, 16'hFFEC);
    push_exp("and_r11", 32'd8);
    push_exp("or_r12", 32'd11);
    push_exp("nor_r13", 32'hFFFF_FFF4);
    push_exp("slt_r14", 32'd1);
    push_exp("addi_neg_r15", 32'hFFFF_FFFF);
    push_exp("slt_neg_r16", 32'd1);
    push_exp("slt_false_r22", 32'd0);
    push_exp("add_wrap_r17", 32'd0);
    push_exp("addi_r23", 32'hFFFF_FFF5);
    release_reset();
    repeat (9) step();
    pop_check(dut.Registers_0.data[11]);
    pop_check(dut.Registers_0.data[12]);
    pop_check(dut.Registers_0.data[13]);
    pop_check(dut.Registers_0.data[14]);
    pop_check(dut.Registers_0.data[15]);
    pop_check(dut.Registers_0.data[16]);
    pop_check(dut.Registers_0.data[22]);
    pop_check(dut.Registers_0.data[17]);
    pop_check(dut.Registers_0.data[23]);

    // Unknown opcode, unknown funct, j
    prog_begin();
    dut.InstructionMemory_0.data[0] = 32'hFC000000;
    dut.InstructionMemory_0.data[1] = enc_r(9, 10, 8, 6'h3F);
    dut.InstructionMemory_0.data[2] = 32'h08000010;
    push_exp("unk_op_pc", 32'd4);
    push_exp("unk_fn_pc", 32'd8);
    push_exp("unk_fn_r8", 32'd8);
`ifdef CPU_JUMP_EN
    push_exp("j_pc", 32'h40);
`else
    push_exp("j_nop_pc", 32'd12);
`endif
    release_reset();
    step();
    pop_check(dut.pc_q);
    step();
    pop_check(dut.pc_q);
    pop_check(dut.Registers_0.data[8]);
    step();
    pop_check(dut.pc_q);

    // Reset mid-run: PC clears at once, state kept, restart at word 0
    prog_begin();
    dut.InstructionMemory_0.data[0] = enc_i(OpAddi, 18, 18, 16'd1);
    dut.InstructionMemory_0.data[1] = enc_i(OpAddi, 0, 19, 16'd7);
    dut.InstructionMemory_0.data[2] = enc_r(18, 19, 20, FnAdd);
    dut.InstructionMemory_0.data[3] = enc_i(OpAddi, 0, 18, 16'd100);
    push_exp("mid_pc3", 32'd12);
    push_exp("mid_rst_pc", 32'd0);
    push_exp("mid_r20_kept", 32'd26);
    push_exp("mid_r18_kept", 32'd19);
    push_exp("mid_restart_pc", 32'd4);
    push_exp("mid_restart_r18", 32'd20);
    release_reset();
    repeat (3) step();
    pop_check(dut.pc_q);
    @(negedge clock);
    reset = 1'b0;
    #1;
    pop_check(dut.pc_q);
    pop_check(dut.Registers_0.data[20]);
    pop_check(dut.Registers_0.data[18]);
    release_reset();
    step();
    pop_check(dut.pc_q);
    pop_check(dut.Registers_0.data[18]);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
